// File: rtl/vga_fb_scheduler_if.sv
// rtl/vga_fb_scheduler_if.sv - writer request channel into the frame-buffer scheduler
interface vga_fb_scheduler_if #(
    parameter int AW = 8,
    parameter int CW = 3
);
    logic            wr_valid;
    logic            wr_ready;
    logic [2*AW-1:0] wr_addr;
    logic [CW-1:0]   wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - single-port frame-buffer arbiter between VGA fetch and a pixel writer
// Optional macro VGA_FB_BLANK_WRITE_EN lends blanked display slots to the writer.
module vga_fb_scheduler #(
    parameter int AW = 8,
    parameter int CW = 3,
    parameter int SW = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_pix_tick,
    input  logic             i_disp_active,
    input  logic [AW-1:0]    i_cur_col,
    input  logic [AW-1:0]    i_cur_row,
    output logic [CW-1:0]    o_pix_rgb,
    output logic             o_pix_valid,
    vga_fb_scheduler_if.slave wr_if,
    output logic [2*AW-1:0]  o_mem_addr,
    output logic             o_mem_we,
    output logic [CW-1:0]    o_mem_wdata,
    input  logic [CW-1:0]    i_mem_rdata,
    output logic [SW-1:0]    o_wr_stall_cnt
);

    // Each display slot travels RD_ISSUE -> RD_DATA -> OUT tagged with what it does at OUT.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_BLANK
    } op_e;

    op_e             r_issue_op, r_data_op;
    op_e             w_issue_op_nxt, w_data_op_nxt;
    logic [CW-1:0]   r_pix_rgb, w_pix_rgb_nxt;
    logic            r_pix_valid, w_pix_valid_nxt;
    logic [2*AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic [CW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [SW-1:0]   r_stall_cnt, w_stall_cnt_nxt;
    logic            w_wr_ready, w_wr_fire, w_rd_req;

`ifdef VGA_FB_BLANK_WRITE_EN
    assign w_wr_ready = ~(i_pix_tick & i_disp_active);
`else
    assign w_wr_ready = ~i_pix_tick;
`endif

    assign w_rd_req  = i_pix_tick & i_disp_active;
    assign w_wr_fire = wr_if.wr_valid & w_wr_ready;

    always_comb begin
        w_issue_op_nxt  = OP_NONE;
        w_data_op_nxt   = r_issue_op;
        w_pix_rgb_nxt   = r_pix_rgb;
        w_pix_valid_nxt = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_stall_cnt_nxt = r_stall_cnt;

        if (i_pix_tick) begin
            w_issue_op_nxt = i_disp_active ? OP_READ : OP_BLANK;
        end

        case (r_data_op)
            OP_READ: begin
                w_pix_rgb_nxt   = i_mem_rdata;
                w_pix_valid_nxt = 1'b1;
            end
            OP_BLANK: w_pix_rgb_nxt = '0;
            default: ;
        endcase

        // w_rd_req and w_wr_fire are mutually exclusive by construction of w_wr_ready.
        if (w_rd_req) begin
            w_mem_addr_nxt = {i_cur_row, i_cur_col};
        end else if (w_wr_fire) begin
            w_mem_addr_nxt  = wr_if.wr_addr;
            w_mem_wdata_nxt = wr_if.wr_data;
            w_mem_we_nxt    = 1'b1;
        end

        if (wr_if.wr_valid && !w_wr_ready && (r_stall_cnt != {SW{1'b1}})) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_op  <= OP_NONE;
            r_data_op   <= OP_NONE;
            r_pix_rgb   <= '0;
            r_pix_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_issue_op  <= w_issue_op_nxt;
            r_data_op   <= w_data_op_nxt;
            r_pix_rgb   <= w_pix_rgb_nxt;
            r_pix_valid <= w_pix_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign wr_if.wr_ready = w_wr_ready;
    assign o_pix_rgb      = r_pix_rgb;
    assign o_pix_valid    = r_pix_valid;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_we       = r_mem_we;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_wr_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - directed self-checking bench for vga_fb_scheduler (SW=4 build)
module tb_vga_fb_scheduler;
    localparam int AW = 8;
    localparam int CW = 3;
    localparam int SW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            pix_tick, disp_active;
    logic [AW-1:0]   cur_col, cur_row;
    logic [CW-1:0]   pix_rgb;
    logic            pix_valid;
    logic [2*AW-1:0] mem_addr;
    logic            mem_we;
    logic [CW-1:0]   mem_wdata, mem_rdata;
    logic [SW-1:0]   wr_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef VGA_FB_BLANK_WRITE_EN
    localparam logic BLANK_READY = 1'b1;
`else
    localparam logic BLANK_READY = 1'b0;
`endif

    vga_fb_scheduler_if #(.AW(AW), .CW(CW)) wr_if ();

    vga_fb_scheduler #(.AW(AW), .CW(CW), .SW(SW)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_pix_tick     (pix_tick),
        .i_disp_active  (disp_active),
        .i_cur_col      (cur_col),
        .i_cur_row      (cur_row),
        .o_pix_rgb      (pix_rgb),
        .o_pix_valid    (pix_valid),
        .wr_if          (wr_if.slave),
        .o_mem_addr     (mem_addr),
        .o_mem_we       (mem_we),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_wr_stall_cnt (wr_stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pix_tick = 1'b0; disp_active = 1'b0;
        cur_col = '0; cur_row = '0; mem_rdata = '0;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        step; step;
        reset = 1'b0;
        chk("rst_rgb", pix_rgb, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", wr_stall_cnt, 0);

        // Test 1: one active display read, data returns in the RD_DATA cycle
        pix_tick = 1'b1; disp_active = 1'b1; cur_row = 8'd5; cur_col = 8'd7;
        step;
        pix_tick = 1'b0;
        chk("t1_addr", mem_addr, 16'h0507);
        chk("t1_we", mem_we, 0);
        chk("t1_valid_c1", pix_valid, 0);
        step;
        mem_rdata = 3'b101;
        chk("t1_valid_c2", pix_valid, 0);
        step;
        mem_rdata = 3'b000;
        chk("t1_valid_c3", pix_valid, 1);
        chk("t1_rgb_c3", pix_rgb, 3'b101);
        step;
        chk("t1_valid_c4", pix_valid, 0);
        chk("t1_rgb_hold", pix_rgb, 3'b101);

        // Test 2: write request colliding with a display tick
        pix_tick = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'h1234; wr_if.wr_data = 3'b011;
        #1;
        chk("t2_ready_tick", wr_if.wr_ready, 0);
        step;
        pix_tick = 1'b0;
        #1;
        chk("t2_stall", wr_stall_cnt, 1);
        chk("t2_ready_free", wr_if.wr_ready, 1);
        chk("t2_rd_addr", mem_addr, 16'h0507);
        chk("t2_rd_we", mem_we, 0);
        step;
        wr_if.wr_valid = 1'b0;
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 16'h1234);
        chk("t2_wdata", mem_wdata, 3'b011);
        step;
        chk("t2_we_drop", mem_we, 0);
        chk("t2_addr_hold", mem_addr, 16'h1234);
        chk("t2_pix_valid", pix_valid, 1);
        chk("t2_pix_rgb", pix_rgb, 0);

        // Test 3: back-to-back ticks starve the writer without losing the write
        reset = 1'b1;
        step;
        reset = 1'b0;
        pix_tick = 1'b1; disp_active = 1'b1;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'h00AB; wr_if.wr_data = 3'b110;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_ready", wr_if.wr_ready, 0);
            step;
            chk("t3_no_we", mem_we, 0);
        end
        pix_tick = 1'b0;
        chk("t3_stall", wr_stall_cnt, 10);
        #1;
        chk("t3_ready_free", wr_if.wr_ready, 1);
        step;
        wr_if.wr_valid = 1'b0;
        chk("t3_we", mem_we, 1);
        chk("t3_addr", mem_addr, 16'h00AB);
        chk("t3_wdata", mem_wdata, 3'b110);
        chk("t3_stall_hold", wr_stall_cnt, 10);
        step; step; step;

        // Test 4: active read followed by a blanked tick
        pix_tick = 1'b1; disp_active = 1'b1; cur_row = 8'd5; cur_col = 8'd7;
        step;
        disp_active = 1'b0; cur_row = 8'd9; cur_col = 8'd9;
        #1;
        chk("t4_blank_ready", wr_if.wr_ready, BLANK_READY);
        chk("t4_rd_addr", mem_addr, 16'h0507);
        step;
        pix_tick = 1'b0; disp_active = 1'b1; mem_rdata = 3'b101;
        chk("t4_no_read_addr", mem_addr, 16'h0507);
        chk("t4_no_read_we", mem_we, 0);
        step;
        mem_rdata = 3'b000;
        chk("t4_valid", pix_valid, 1);
        chk("t4_rgb", pix_rgb, 3'b101);
        step;
        chk("t4_blank_valid", pix_valid, 0);
        chk("t4_blank_rgb", pix_rgb, 0);
        step;
        chk("t4_idle_rgb", pix_rgb, 0);

        // Test 5: reset lands while a read is in flight and a write is accepted
        pix_tick = 1'b1; cur_row = 8'd1; cur_col = 8'd2; mem_rdata = 3'b111;
        step;
        pix_tick = 1'b0;
        chk("t5_addr", mem_addr, 16'h0102);
        reset = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'h4321; wr_if.wr_data = 3'b001;
        step;
        reset = 1'b0; wr_if.wr_valid = 1'b0;
        chk("t5_rgb", pix_rgb, 0);
        chk("t5_valid", pix_valid, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_we", mem_we, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_stall", wr_stall_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("t5_no_valid", pix_valid, 0);
        end
        mem_rdata = 3'b000;

        // Test 6: stall counter saturation at 2^SW-1
        pix_tick = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_addr = 16'h0F0F; wr_if.wr_data = 3'b010;
        for (int i = 0; i < 14; i++) step;
        chk("t6_cnt14", wr_stall_cnt, 14);
        step;
        chk("t6_cnt15", wr_stall_cnt, 15);
        step;
        chk("t6_sat_a", wr_stall_cnt, 15);
        step;
        chk("t6_sat_b", wr_stall_cnt, 15);
        pix_tick = 1'b0;
        step;
        wr_if.wr_valid = 1'b0;
        chk("t6_we", mem_we, 1);
        chk("t6_addr", mem_addr, 16'h0F0F);
        chk("t6_sat_c", wr_stall_cnt, 15);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
